// File: rtl/calc_pkg.sv
// calc_pkg: operator codes, error causes, FSM states and operator classification
// shared by the postfix evaluator and its operand stack.
package calc_pkg;

    localparam int OP_W = 8;
    localparam int TAG_W = 2;

    localparam logic [OP_W-1:0] OP_ADD    = 8'h2A;
    localparam logic [OP_W-1:0] OP_SUB    = 8'h2B;
    localparam logic [OP_W-1:0] OP_MUL    = 8'h2C;
    localparam logic [OP_W-1:0] OP_DIV    = 8'h2D;
    localparam logic [OP_W-1:0] OP_BIN_F2 = 8'hF2;
    localparam logic [OP_W-1:0] OP_BIN_F3 = 8'hF3;
    localparam logic [OP_W-1:0] OP_UN_F0  = 8'hF0;
    localparam logic [OP_W-1:0] OP_UN_F1  = 8'hF1;
    localparam logic [OP_W-1:0] OP_UN_F4  = 8'hF4;
    localparam logic [OP_W-1:0] OP_UN_F5  = 8'hF5;
    localparam logic [OP_W-1:0] OP_UN_F6  = 8'hF6;

    localparam logic [TAG_W-1:0] TAG_CONST = 2'b00;

    typedef enum logic [2:0] {
        ERR_OK         = 3'd0,
        ERR_UNDERFLOW  = 3'd1,
        ERR_OVERFLOW   = 3'd2,
        ERR_UNKNOWN_OP = 3'd3,
        ERR_DOMAIN     = 3'd4,
        ERR_TIMEOUT    = 3'd5,
        ERR_MALFORMED  = 3'd6
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } eval_state_t;

    function automatic logic is_binary(input logic [OP_W-1:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV ||
               op == OP_BIN_F2 || op == OP_BIN_F3;
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return op == OP_UN_F0 || op == OP_UN_F1 || op == OP_UN_F4 ||
               op == OP_UN_F5 || op == OP_UN_F6;
    endfunction

endpackage

// File: rtl/postfix_stack.sv
// postfix_stack: LIFO operand stack with single push and one/two-entry pop,
// exposing top and second entries combinationally.
module postfix_stack #(
    parameter int DEPTH   = 10,
    parameter int TOKEN_W = 44
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [TOKEN_W-1:0]           i_data,
    input  logic                         i_pop1,
    input  logic                         i_pop2,
    output logic [$clog2(DEPTH+1)-1:0]   o_sp,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [TOKEN_W-1:0]           o_top,
    output logic [TOKEN_W-1:0]           o_second
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [TOKEN_W-1:0] r_mem [DEPTH];
    logic [SW-1:0]      r_sp;
    logic [SW-1:0]      w_ti;
    logic [SW-1:0]      w_si;

    assign w_ti     = r_sp - SW'(1);
    assign w_si     = r_sp - SW'(2);
    assign o_sp     = r_sp;
    assign o_full   = r_sp == SW'(DEPTH);
    assign o_empty  = r_sp == '0;
    assign o_top    = o_empty ? '0 : r_mem[w_ti[AW-1:0]];
    assign o_second = (r_sp < SW'(2)) ? '0 : r_mem[w_si[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sp <= '0;
        else if (i_clear) r_sp <= '0;
        else if (i_push && !o_full) r_sp <= r_sp + SW'(1);
        else if (i_pop2 && r_sp >= SW'(2)) r_sp <= w_si;
        else if (i_pop1 && !o_empty) r_sp <= w_ti;
    end

    always_ff @(posedge clock) begin
        if (i_push && !o_full && !i_clear) r_mem[r_sp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/postfix_eval_engine.sv
// postfix_eval_engine: walks a postfix token array, keeps an operand stack and
// dispatches each operator to an external arithmetic unit over a req/done port.
module postfix_eval_engine
    import calc_pkg::*;
#(
    parameter int DEPTH   = 10,
    parameter int MANT_W  = 34,
    parameter int EXP_W   = 7,
    parameter int TOKEN_W = 3 + MANT_W + EXP_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              i_start,
    input  logic                              i_abort,
    input  logic [$clog2(DEPTH+1)-1:0]        i_postfix_size,
    input  logic [DEPTH-1:0][TOKEN_W-1:0]     i_postfix,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [TOKEN_W-1:0]                o_answer,
    output logic                              o_error,
    output logic [2:0]                        o_err_code,
    output logic                              o_unit_req,
    output logic [7:0]                        o_unit_op,
    output logic                              o_unit_unary,
    output logic                              o_unit_sign_a,
    output logic                              o_unit_sign_b,
    output logic [MANT_W-1:0]                 o_unit_mant_a,
    output logic [MANT_W-1:0]                 o_unit_mant_b,
    output logic [EXP_W-1:0]                  o_unit_exp_a,
    output logic [EXP_W-1:0]                  o_unit_exp_b,
    input  logic                              i_unit_done,
    input  logic                              i_unit_err,
    input  logic                              i_unit_sign_res,
    input  logic [MANT_W-1:0]                 i_unit_mant_res,
    input  logic [EXP_W-1:0]                  i_unit_exp_res
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam int VW = TOKEN_W - TAG_W;

    eval_state_t        r_state, w_state_nxt;
    err_code_t          r_err_code, w_fail_code;
    logic               r_start_d, r_busy, r_done, r_error, r_unit_req, r_unit_unary;
    logic [SW-1:0]      r_idx;
    logic [OP_W-1:0]    r_op, r_unit_op;
    logic [WW-1:0]      r_wdog;
    logic [TOKEN_W-1:0] r_answer;
    logic [VW-1:0]      r_opa, r_opb;

    logic               w_start_edge, w_abort, w_accept, w_fail, w_finish, w_issue;
    logic               w_push, w_pop1, w_pop2, w_idx_inc, w_op_latch, w_bin;
    logic               w_full, w_empty;
    logic [SW-1:0]      w_sp;
    logic [TOKEN_W-1:0] w_tok;
    logic [TAG_W-1:0]   w_tag;
    logic [OP_W-1:0]    w_code;
    logic [VW-1:0]      w_push_data, w_top, w_second;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_abort      = i_abort && r_state != S_IDLE;
    assign w_tok        = i_postfix[r_idx[AW-1:0]];
    assign w_tag        = w_tok[TOKEN_W-1 -: TAG_W];
    assign w_code       = w_tok[OP_W-1:0];
    assign w_bin        = is_binary(r_op);

    // Stack holds values only; every stacked entry is a constant, so the tag is implicit.
    postfix_stack #(.DEPTH(DEPTH), .TOKEN_W(VW)) u_stack (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .i_pop1   (w_pop1),
        .i_pop2   (w_pop2),
        .o_sp     (w_sp),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_top    (w_top),
        .o_second (w_second)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_fail_code = ERR_OK;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_push_data = w_tok[VW-1:0];
        w_pop1      = 1'b0;
        w_pop2      = 1'b0;
        w_idx_inc   = 1'b0;
        w_op_latch  = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        w_accept = 1'b1;
                        if (i_postfix_size == '0 || i_postfix_size > SW'(DEPTH)) begin
                            w_fail      = 1'b1;
                            w_fail_code = ERR_MALFORMED;
                        end else begin
                            w_state_nxt = S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_idx == i_postfix_size) begin
                        w_state_nxt = S_FINISH;
                    end else if (w_tag == TAG_CONST) begin
                        w_fail      = w_full;
                        w_fail_code = w_full ? ERR_OVERFLOW : ERR_OK;
                        w_push      = !w_full;
                        w_idx_inc   = !w_full;
                    end else if (is_binary(w_code) || is_unary(w_code)) begin
                        w_op_latch  = 1'b1;
                        w_idx_inc   = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_UNKNOWN_OP;
                    end
                end
                S_ISSUE: begin
                    if (w_bin ? w_sp < SW'(2) : w_empty) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_UNDERFLOW;
                    end else begin
                        w_issue     = 1'b1;
                        w_pop2      = w_bin;
                        w_pop1      = !w_bin;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_unit_done) begin
                        w_fail      = i_unit_err;
                        w_fail_code = i_unit_err ? ERR_DOMAIN : ERR_OK;
                        w_push      = !i_unit_err;
                        w_push_data = {i_unit_sign_res, i_unit_mant_res, i_unit_exp_res};
                        w_state_nxt = S_READ;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_TIMEOUT;
                    end
                end
                S_FINISH: begin
                    w_finish    = w_sp == SW'(1);
                    w_fail      = w_sp != SW'(1);
                    w_fail_code = w_finish ? ERR_OK : ERR_MALFORMED;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_fail) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_d    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_OK;
            r_answer     <= '0;
            r_idx        <= '0;
            r_op         <= '0;
            r_wdog       <= '0;
            r_unit_req   <= 1'b0;
            r_unit_op    <= '0;
            r_unit_unary <= 1'b0;
            r_opa        <= '0;
            r_opb        <= '0;
        end else begin
            r_start_d  <= i_start;
            r_done     <= w_fail | w_finish;
            r_unit_req <= w_issue;
            r_wdog     <= w_issue ? '0 : (r_state == S_WAIT ? r_wdog + WW'(1) : r_wdog);
            if (w_accept) begin
                r_idx      <= '0;
                r_error    <= 1'b0;
                r_err_code <= ERR_OK;
                r_busy     <= 1'b1;
            end
            if (w_idx_inc) r_idx <= r_idx + SW'(1);
            if (w_op_latch) r_op <= w_code;
            if (w_issue) begin
                r_unit_op    <= r_op;
                r_unit_unary <= !w_bin;
                r_opa        <= w_top;
                r_opb        <= w_bin ? w_second : '0;
            end
            if (w_finish) begin
                r_answer <= {TAG_CONST, w_top};
                r_busy   <= 1'b0;
            end
            if (w_fail) begin
                r_answer   <= '0;
                r_error    <= 1'b1;
                r_err_code <= w_fail_code;
                r_busy     <= 1'b0;
            end
            if (w_abort) r_busy <= 1'b0;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_answer      = r_answer;
    assign o_error       = r_error;
    assign o_err_code    = r_err_code;
    assign o_unit_req    = r_unit_req;
    assign o_unit_op     = r_unit_op;
    assign o_unit_unary  = r_unit_unary;
    assign o_unit_sign_a = r_opa[VW-1];
    assign o_unit_sign_b = r_opb[VW-1];
    assign o_unit_mant_a = r_opa[VW-2 -: MANT_W];
    assign o_unit_mant_b = r_opb[VW-2 -: MANT_W];
    assign o_unit_exp_a  = r_opa[EXP_W-1:0];
    assign o_unit_exp_b  = r_opb[EXP_W-1:0];

endmodule
